// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the dmem_sync data memory:
//   - state_e    : controller state (initialising / running)
//   - INIT_ZERO  : fill every word with zero during initialisation
//   - INIT_RAMP  : lower half holds i, upper half holds -i (mod 2^DATA_W)
//   - pattern()  : initial contents of one word, returned 64 bits wide and
//                  already masked to data_w bits; callers truncate to DATA_W.
// -----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int unsigned INIT_ZERO = 0;
    localparam int unsigned INIT_RAMP = 1;

    function automatic logic [63:0] pattern(
        input int unsigned idx,
        input int unsigned depth,
        input int unsigned data_w,
        input int unsigned mode
    );
        logic [63:0] mask;
        logic [63:0] half;
        logic [63:0] val;
        mask = (data_w >= 64) ? '1 : ((64'd1 << data_w) - 64'd1);
        half = 64'(depth / 2);
        if (mode == INIT_ZERO) begin
            val = '0;
        end else if (64'(idx) < half) begin
            val = 64'(idx);
        end else begin
            // Upper half counts downward from zero: word H+i holds -i.
            val = 64'd0 - (64'(idx) - half);
        end
        return val & mask;
    endfunction

endpackage

// File: rtl/dmem_init_seq.sv
// -----------------------------------------------------------------------------
// dmem_init_seq
// Walks the word index from 0 to DEPTH-1, one word per clock, presenting the
// initial value of each word on a write port. Stops after the last word.
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset; restarts the walk at 0
//   init_we   out  write strobe, high while the walk is still in progress
//   init_addr out  word index being written this cycle
//   init_data out  initial value for init_addr
//   done      out  high once the final word has been written
// -----------------------------------------------------------------------------
module dmem_init_seq
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 32,
    parameter int INIT_MODE = 1,
    parameter int IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              init_we,
    output logic [IDX_W-1:0]  init_addr,
    output logic [DATA_W-1:0] init_data,
    output logic              done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;

    always_comb begin
        idx_d  = idx_q;
        done_d = done_q;
        if (!done_q) begin
            if (idx_q == LAST_IDX) begin
                done_d = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            done_q <= done_d;
        end
    end

    assign init_we   = !done_q;
    assign init_addr = idx_q;
    assign init_data = DATA_W'(pattern(32'(idx_q), DEPTH, DATA_W, INIT_MODE));
    assign done      = done_q;

endmodule

// File: rtl/dmem_sync.sv
// -----------------------------------------------------------------------------
// dmem_sync
// Synchronous-read data memory for the 8-bit datapath. After reset the
// built-in sequencer fills every word (one per clock) and Ready stays low;
// afterwards one read and/or one write is served per clock with a registered
// read result one cycle later.
// Ports:
//   CLK        in   clock, all state changes on the rising edge
//   RST_N      in   asynchronous active-low reset
//   Address    in   word address for read and/or write
//   writeData  in   write data
//   MemRead    in   read request
//   MemWrite   in   write request
//   readData   out  registered read result (holds when no read is issued)
//   readValid  out  one-cycle strobe marking a fresh readData
//   Ready      out  high once initialisation has finished
//   AddrErr    out  one-cycle pulse for a request with Address >= DEPTH
// DEPTH must be even, at least 2, and no larger than 2^ADDR_W.
// -----------------------------------------------------------------------------
module dmem_sync
    import dmem_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 32,
    parameter int INIT_MODE = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] writeData,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [DATA_W-1:0] readData,
    output logic              readValid,
    output logic              Ready,
    output logic              AddrErr
);

    localparam int IDX_W = $clog2(DEPTH);

    // Storage: not reset; the init sequence overwrites every word instead.
    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic              read_valid_q, read_valid_d;
    logic              addr_err_q, addr_err_d;

    logic              init_we;
    logic [IDX_W-1:0]  init_addr;
    logic [DATA_W-1:0] init_data;
    logic              init_done;
    logic              init_last;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              in_range;
    logic [IDX_W-1:0]  mem_idx;

    dmem_init_seq #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_MODE (INIT_MODE),
        .IDX_W     (IDX_W)
    ) u_init_seq (
        .clk       (CLK),
        .rst_n     (RST_N),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .done      (init_done)
    );

    // Compare with one extra bit so DEPTH == 2^ADDR_W does not wrap to 0.
    assign in_range  = ({1'b0, Address} < (ADDR_W + 1)'(DEPTH));
    assign mem_idx   = Address[IDX_W-1:0];

    // The edge that writes the final word is also the edge that raises Ready.
    assign init_last = init_we && !init_done && (init_addr == IDX_W'(DEPTH - 1));

    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        addr_err_d   = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = init_addr;
        mem_wdata    = init_data;

        case (state_q)
            S_INIT: begin
                // User requests are ignored while the sequencer owns the port.
                mem_we = init_we;
                if (init_last) begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                end
            end
            S_RUN: begin
                mem_waddr  = mem_idx;
                mem_wdata  = writeData;
                mem_we     = MemWrite && in_range;
                addr_err_d = (MemRead || MemWrite) && !in_range;
                if (MemRead) begin
                    read_valid_d = 1'b1;
                    if (!in_range) begin
                        read_data_d = '0;
                    end else if (MemWrite) begin
                        // Write-first: a same-cycle write is what the read sees.
                        read_data_d = writeData;
                    end else begin
                        read_data_d = mem_q[mem_idx];
                    end
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_INIT;
            ready_q      <= 1'b0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign readData  = read_data_q;
    assign readValid = read_valid_q;
    assign Ready     = ready_q;
    assign AddrErr   = addr_err_q;

endmodule

// File: tb/tb_dmem_sync.sv
// -----------------------------------------------------------------------------
// tb_dmem_sync
// Self-checking bench for dmem_sync (DEPTH=32, DATA_W=8, ADDR_W=8,
// INIT_MODE=1). Expected read data is queued when a read is issued and
// compared when readValid appears.
// -----------------------------------------------------------------------------
module tb_dmem_sync;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int DEPTH     = 32;
    localparam int INIT_MODE = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] writeData;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] readData;
    logic              readValid;
    logic              Ready;
    logic              AddrErr;

    int n_vec  = 0;
    int n_miss = 0;

    logic [DATA_W-1:0] model [DEPTH];
    logic [DATA_W-1:0] exp_q [$];

    always #5 clk = ~clk;

    dmem_sync #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .INIT_MODE (INIT_MODE)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .Address   (Address),
        .writeData (writeData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .readData  (readData),
        .readValid (readValid),
        .Ready     (Ready),
        .AddrErr   (AddrErr)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] init_word(input int i);
        if (i < DEPTH / 2) return 8'(i);
        return 8'(256 - (i - DEPTH / 2));
    endfunction

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) model[i] = init_word(i);
    endtask

    task automatic clear_inputs();
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Address   = '0;
        writeData = '0;
    endtask

    // One request, sampled at the next rising edge.
    task automatic req(input bit rd, input bit wr, input logic [7:0] addr, input logic [7:0] wdata);
        bit          inr;
        logic [7:0]  exp;
        MemRead   = rd;
        MemWrite  = wr;
        Address   = addr;
        writeData = wdata;
        @(posedge clk);
        inr = (addr < DEPTH);
        if (rd) begin
            if (!inr)    exp = 8'h00;
            else if (wr) exp = wdata;
            else         exp = model[addr[4:0]];
            exp_q.push_back(exp);
        end
        if (wr && inr) model[addr[4:0]] = wdata;
        #1;
        check("rd_valid", readValid, 32'(rd));
        check("addr_err", AddrErr, 32'((rd || wr) && !inr));
    endtask

    task automatic idle(input int n);
        clear_inputs();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("idle_valid", readValid, 0);
            check("idle_err", AddrErr, 0);
        end
    endtask

    // Count init edges from release; Ready must rise exactly after edge DEPTH.
    task automatic init_edges(input int n, input bit inject);
        for (int e = 1; e <= n; e++) begin
            clear_inputs();
            if (inject && e == 4) begin
                MemWrite  = 1'b1;
                Address   = 8'd2;
                writeData = 8'h77;
            end
            if (inject && e == 6) begin
                MemRead = 1'b1;
                Address = 8'd5;
            end
            if (inject && e == 8) begin
                MemRead = 1'b1;
                Address = 8'd40;
            end
            @(posedge clk);
            #1;
            check("init_ready", Ready, 32'(e == DEPTH));
            check("init_valid", readValid, 0);
            check("init_err", AddrErr, 0);
        end
        clear_inputs();
    endtask

    always @(negedge clk) begin
        if (rst_n && readValid) begin
            if (exp_q.size() == 0) check("rd_spurious", 1, 0);
            else                   check("rd_data", readData, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", readData, 0);
        check("rst_valid", readValid, 0);
        check("rst_ready", Ready, 0);
        check("rst_err", AddrErr, 0);

        // Release and initialise, with requests that must be ignored.
        rst_n = 1'b1;
        init_edges(DEPTH, 1'b1);
        model_init();

        req(1, 0, 8'd5, 8'h00);
        req(1, 0, 8'd21, 8'h00);
        req(1, 0, 8'd16, 8'h00);
        req(1, 0, 8'd2, 8'h00);
        idle(1);

        // Write then read.
        req(0, 1, 8'd3, 8'hA5);
        req(1, 0, 8'd3, 8'h00);
        idle(1);

        // Simultaneous read and write with forwarding.
        req(1, 1, 8'd7, 8'h3C);
        req(1, 0, 8'd7, 8'h00);

        // Out of range.
        req(0, 1, 8'd40, 8'h11);
        req(1, 0, 8'd40, 8'h00);
        idle(1);
        req(1, 0, 8'd255, 8'h00);
        req(1, 1, 8'd32, 8'h99);

        // Sweep every word back-to-back.
        for (int a = 0; a < DEPTH; a++) req(1, 0, 8'(a), 8'h00);
        idle(2);
        check("sb_drain", 32'(exp_q.size()), 0);

        // Asynchronous reset while running: outputs clear before any edge.
        rst_n = 1'b0;
        #1;
        check("arst_data", readData, 0);
        check("arst_ready", Ready, 0);
        check("arst_valid", readValid, 0);
        check("arst_err", AddrErr, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        init_edges(10, 1'b0);

        // Reset mid-init, then a full init is needed again.
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", Ready, 0);
        check("mid_rst_data", readData, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        init_edges(DEPTH, 1'b0);
        model_init();

        req(1, 0, 8'd3, 8'h00);
        req(1, 0, 8'd7, 8'h00);
        req(1, 0, 8'd20, 8'h00);
        req(1, 0, 8'd31, 8'h00);
        idle(1);
        check("sb_drain_end", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
